// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and types for the sprite register-update scheduler
package sprite_pkg;

  localparam logic [5:0] SPR_ADDR_X      = 6'h04;
  localparam logic [5:0] SPR_ADDR_Y      = 6'h06;
  localparam logic [5:0] SPR_ADDR_CTRL   = 6'h08;
  localparam logic [5:0] SPR_ADDR_BITMAP = 6'h10;

  typedef enum logic {S_IDLE, S_DRAIN} sched_state_t;

endpackage

// File: rtl/sprite_wr_fifo.sv
// rtl/sprite_wr_fifo.sv - synchronous FIFO holding buffered {addr,data} register writes
module sprite_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic          w_wr;
  logic          w_rd;

  assign w_rd = i_pop && !o_empty;
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= r_level + (PW+1)'(w_wr) - (PW+1)'(w_rd);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (PW+1)'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/sprite_update_sched.sv
// rtl/sprite_update_sched.sv - buffers CPU register writes and replays committed batches during vblank
module sprite_update_sched
  import sprite_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_data,
  input  logic                   commit,
  input  logic                   vblank,
  output logic                   eng_we,
  output logic [AW-1:0]          eng_addr,
  output logic [DW-1:0]          eng_data,
  input  logic                   eng_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   late,
  input  logic                   late_clr,
  output logic                   done
);

  localparam int LW = $clog2(DEPTH) + 1;

  sched_state_t r_state;
  logic [LW-1:0] r_pending;
  logic          r_vblank_q;
  logic          r_late;
  logic          r_done;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_rise;
  logic [AW+DW-1:0] w_head;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_next;
  logic [LW-1:0] w_pending_next;

  sprite_wr_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({req_addr, req_data}),
    .o_rdata (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_ready = !w_full;
  assign w_push    = req_valid && !w_full;
  // Writes stop in the very cycle vblank falls, so nothing lands mid-frame.
  assign eng_we    = (r_state == S_DRAIN) && vblank && (r_pending != '0) && !w_empty;
  assign w_pop     = eng_we && eng_ready;
  assign w_rise    = vblank && !r_vblank_q;

  assign w_level_next   = w_level + LW'(w_push) - LW'(w_pop);
  assign w_pending_next = commit ? w_level_next : (r_pending - LW'(w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_vblank_q <= 1'b0;
      r_late     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_vblank_q <= vblank;
      r_pending  <= w_pending_next;
      r_done     <= (r_state == S_DRAIN) && w_pop && (w_pending_next == '0);
      if (late_clr) r_late <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise && (r_pending != '0)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!vblank) begin
            r_state <= S_IDLE;
            if (r_pending != '0) r_late <= 1'b1;
          end else if (w_pending_next == '0) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign {eng_addr, eng_data} = w_head;
  assign level   = w_level;
  assign pending = r_pending;
  assign late    = r_late;
  assign done    = r_done;

endmodule

// File: tb/tb_sprite_update_sched.sv
// tb/tb_sprite_update_sched.sv - directed table-driven bench for sprite_update_sched
module tb_sprite_update_sched;

  localparam int DEPTH = 8;
  localparam int AW    = 6;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          commit;
  logic          vblank;
  logic          eng_we;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_data;
  logic          eng_ready;
  logic [3:0]    level;
  logic [3:0]    pending;
  logic          late;
  logic          late_clr;
  logic          done;

  sprite_update_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .commit    (commit),
    .vblank    (vblank),
    .eng_we    (eng_we),
    .eng_addr  (eng_addr),
    .eng_data  (eng_data),
    .eng_ready (eng_ready),
    .level     (level),
    .pending   (pending),
    .late      (late),
    .late_clr  (late_clr),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  a;
    logic [15:0] d;
    logic        c, vb, er, lc;
    logic        we, hd;
    logic [5:0]  ea;
    logic [15:0] ed;
    logic [3:0]  lvl, pend;
    logic        lt, dn;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic v, input logic [5:0] a, input logic [15:0] d,
                     input logic c, input logic vb, input logic er, input logic lc,
                     input logic we, input logic hd, input logic [5:0] ea, input logic [15:0] ed,
                     input logic [3:0] lvl, input logic [3:0] pend, input logic lt, input logic dn);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.c = c; r.vb = vb; r.er = er; r.lc = lc;
    r.we = we; r.hd = hd; r.ea = ea; r.ed = ed; r.lvl = lvl; r.pend = pend; r.lt = lt; r.dn = dn;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0d: got %0h want %0h", name, tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_addr = '0; req_data = '0; commit = 0;
    late_clr = 0; eng_ready = 1;
  endtask

  initial begin
    int accepted;
    int cyc;
    rst = 1'b1;
    idle_inputs();
    vblank = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // v  a     d        c vb er lc | we hd ea    ed       lvl pend lt dn
    add(0, 6'h00, 16'h0000, 0, 0, 1, 0,  0, 1, 6'h00, 16'h0000, 0, 0, 0, 0);
    add(1, 6'h04, 16'h1020, 0, 0, 1, 0,  0, 1, 6'h00, 16'h0000, 0, 0, 0, 0);
    add(1, 6'h06, 16'hFFFF, 0, 0, 1, 0,  0, 1, 6'h04, 16'h1020, 1, 0, 0, 0);
    add(1, 6'h08, 16'h00F0, 0, 0, 1, 0,  0, 1, 6'h04, 16'h1020, 2, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 1, 0, 1, 0,  0, 1, 6'h04, 16'h1020, 3, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h04, 16'h1020, 3, 3, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h04, 16'h1020, 3, 3, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h06, 16'hFFFF, 2, 2, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h08, 16'h00F0, 1, 1, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h00, 16'h0000, 0, 0, 0, 1);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 0,  0, 1, 6'h00, 16'h0000, 0, 0, 0, 0);
    add(1, 6'h0A, 16'h1111, 0, 0, 1, 0,  0, 1, 6'h00, 16'h0000, 0, 0, 0, 0);
    add(1, 6'h0C, 16'h2222, 0, 0, 1, 0,  0, 1, 6'h0A, 16'h1111, 1, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 1, 0, 1, 0,  0, 1, 6'h0A, 16'h1111, 2, 0, 0, 0);
    add(1, 6'h0E, 16'h3333, 0, 0, 1, 0,  0, 1, 6'h0A, 16'h1111, 2, 2, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h0A, 16'h1111, 3, 2, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h0A, 16'h1111, 3, 2, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h0C, 16'h2222, 2, 1, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h0E, 16'h3333, 1, 0, 0, 1);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 1, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h0E, 16'h3333, 1, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h0E, 16'h3333, 1, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 1, 0, 0, 0);
    add(1, 6'h10, 16'hA000, 0, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 1, 0, 0, 0);
    add(1, 6'h12, 16'hA001, 0, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 2, 0, 0, 0);
    add(1, 6'h14, 16'hA002, 0, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 3, 0, 0, 0);
    add(1, 6'h16, 16'hA003, 0, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 4, 0, 0, 0);
    add(1, 6'h18, 16'hA004, 0, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 5, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 1, 0, 1, 0,  0, 1, 6'h0E, 16'h3333, 6, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h0E, 16'h3333, 6, 6, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h0E, 16'h3333, 6, 6, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h10, 16'hA000, 5, 5, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h12, 16'hA001, 4, 4, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 1,  0, 1, 6'h14, 16'hA002, 3, 3, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 0,  0, 1, 6'h14, 16'hA002, 3, 3, 1, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h14, 16'hA002, 3, 3, 1, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h14, 16'hA002, 3, 3, 1, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h16, 16'hA003, 2, 2, 1, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h18, 16'hA004, 1, 1, 1, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 0, 6'h00, 16'h0000, 0, 0, 1, 1);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 1,  0, 0, 6'h00, 16'h0000, 0, 0, 1, 0);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 0,  0, 0, 6'h00, 16'h0000, 0, 0, 0, 0);
    add(1, 6'h20, 16'hB000, 0, 0, 1, 0,  0, 0, 6'h00, 16'h0000, 0, 0, 0, 0);
    add(1, 6'h22, 16'hB001, 0, 0, 1, 0,  0, 1, 6'h20, 16'hB000, 1, 0, 0, 0);
    add(1, 6'h24, 16'hB002, 0, 0, 1, 0,  0, 1, 6'h20, 16'hB000, 2, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 1, 0, 1, 0,  0, 1, 6'h20, 16'hB000, 3, 0, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 1, 6'h20, 16'hB000, 3, 3, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h20, 16'hB000, 3, 3, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 0, 0,  1, 1, 6'h22, 16'hB001, 2, 2, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 0, 0,  1, 1, 6'h22, 16'hB001, 2, 2, 0, 0);
    add(1, 6'h26, 16'hB003, 0, 1, 1, 0,  1, 1, 6'h22, 16'hB001, 2, 2, 0, 0);
    add(0, 6'h00, 16'h0000, 1, 1, 1, 0,  1, 1, 6'h24, 16'hB002, 2, 1, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  1, 1, 6'h26, 16'hB003, 1, 1, 0, 0);
    add(0, 6'h00, 16'h0000, 0, 1, 1, 0,  0, 0, 6'h00, 16'h0000, 0, 0, 0, 1);
    add(0, 6'h00, 16'h0000, 0, 0, 1, 0,  0, 0, 6'h00, 16'h0000, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = vecs[i].v; req_addr = vecs[i].a; req_data = vecs[i].d;
      commit = vecs[i].c; vblank = vecs[i].vb; eng_ready = vecs[i].er; late_clr = vecs[i].lc;
      #1;
      chk("eng_we", i, 32'(eng_we), 32'(vecs[i].we));
      if (vecs[i].hd) begin
        chk("eng_addr", i, 32'(eng_addr), 32'(vecs[i].ea));
        chk("eng_data", i, 32'(eng_data), 32'(vecs[i].ed));
      end
      chk("level", i, 32'(level), 32'(vecs[i].lvl));
      chk("pending", i, 32'(pending), 32'(vecs[i].pend));
      chk("late", i, 32'(late), 32'(vecs[i].lt));
      chk("done", i, 32'(done), 32'(vecs[i].dn));
      chk("req_ready", i, 32'(req_ready), 32'(vecs[i].lvl != 4'd8));
    end

    // Backpressure: hold req_valid until the FIFO fills, then drain one batch.
    idle_inputs();
    vblank = 0;
    accepted = 0;
    cyc = 0;
    while (accepted < 8 && cyc < 20) begin
      @(negedge clk);
      req_valid = 1; req_addr = 6'(6'h30 + accepted); req_data = 16'(16'hC000 + accepted);
      #1;
      if (req_ready) accepted++;
      cyc++;
    end
    chk("bp_accepted", 100, 32'(accepted), 32'd8);
    @(negedge clk);
    req_addr = 6'h38; req_data = 16'hC008;
    #1;
    chk("bp_full_ready", 101, 32'(req_ready), 32'd0);
    chk("bp_full_level", 101, 32'(level), 32'd8);
    @(negedge clk); commit = 1; #1;
    chk("bp_commit_ready", 102, 32'(req_ready), 32'd0);
    @(negedge clk); commit = 0; vblank = 1; #1;
    chk("bp_rise_we", 103, 32'(eng_we), 32'd0);
    chk("bp_pending", 103, 32'(pending), 32'd8);
    @(negedge clk); #1;
    chk("bp_first_we", 104, 32'(eng_we), 32'd1);
    chk("bp_first_addr", 104, 32'(eng_addr), 32'h30);
    chk("bp_first_ready", 104, 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("bp_ninth_ready", 105, 32'(req_ready), 32'd1);
    chk("bp_level7", 105, 32'(level), 32'd7);
    chk("bp_addr1", 105, 32'(eng_addr), 32'h31);
    for (int k = 2; k < 8; k++) begin
      @(negedge clk); req_valid = 0; #1;
      chk("bp_drain_we", 106 + k, 32'(eng_we), 32'd1);
      chk("bp_drain_addr", 106 + k, 32'(eng_addr), 32'(6'h30 + k));
    end
    @(negedge clk); #1;
    chk("bp_end_we", 120, 32'(eng_we), 32'd0);
    chk("bp_end_done", 120, 32'(done), 32'd1);
    chk("bp_end_level", 120, 32'(level), 32'd1);
    chk("bp_end_pending", 120, 32'(pending), 32'd0);
    chk("bp_ninth_head", 120, 32'(eng_addr), 32'h38);
    chk("bp_ninth_data", 120, 32'(eng_data), 32'hC008);

    // Asynchronous reset in the middle of a drain.
    @(negedge clk); vblank = 0; req_valid = 1; req_addr = 6'h3A; req_data = 16'hD000; commit = 1;
    @(negedge clk); req_valid = 0; commit = 0; vblank = 1; #1;
    chk("rst_pending", 130, 32'(pending), 32'd2);
    @(negedge clk); #1;
    chk("rst_pre_we", 131, 32'(eng_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_we", 132, 32'(eng_we), 32'd0);
    chk("rst_level", 132, 32'(level), 32'd0);
    chk("rst_ready", 132, 32'(req_ready), 32'd1);
    chk("rst_pending0", 132, 32'(pending), 32'd0);
    chk("rst_addr", 132, 32'(eng_addr), 32'd0);
    @(negedge clk); rst = 1'b0; vblank = 0;
    @(negedge clk); vblank = 1; #1;
    @(negedge clk); #1;
    chk("rst_no_drain", 133, 32'(eng_we), 32'd0);
    vblank = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
